// File: rtl/cp0_regs.sv
// MIPS CP0 subset: BadVAddr, Count, Compare, Status, Cause and EPC with a divided timer and a 2-flop interrupt synchronizer.
// Register updates take effect on the next edge; MFC0 reads are combinational, and the block never stalls.
module cp0_regs #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_rdata,
    input  logic        is_exception,
    input  logic [4:0]  excep_code,
    input  logic        is_bd,
    input  logic [31:0] excep_pc,
    input  logic        we_badvaddr,
    input  logic [31:0] badvaddr,
    input  logic        eret,
    input  logic [5:0]  hardware_int,
    output logic        is_ie,
    output logic        is_exl,
    output logic [7:0]  int_mask,
    output logic [1:0]  soft_int,
    output logic [31:0] epc,
    output logic [5:0]  pending_hw_int
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [3:0] DIV_LAST      = 4'(COUNT_DIV - 1);

    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] epc_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic        ti_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exc_code_q;
    logic [3:0]  div_q;
    logic [5:0]  hw_sync1_q;
    logic [5:0]  hw_sync2_q;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] status_word, cause_word;

    assign wr_count   = mtc0_we && (mtc0_addr == ADDR_COUNT);
    assign wr_compare = mtc0_we && (mtc0_addr == ADDR_COMPARE);
    assign wr_status  = mtc0_we && (mtc0_addr == ADDR_STATUS);
    assign wr_cause   = mtc0_we && (mtc0_addr == ADDR_CAUSE);
    assign wr_epc     = mtc0_we && (mtc0_addr == ADDR_EPC);

    assign pending_hw_int = {hw_sync2_q[5] | ti_q, hw_sync2_q[4:0]};
    assign is_ie          = ie_q;
    assign is_exl         = exl_q;
    assign int_mask       = im_q;
    assign soft_int       = ip_sw_q;
    assign epc            = epc_q;

    // BEV is hardwired, so Status reads 0x0040_0000 even while reset is held.
    assign status_word = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_word  = {bd_q, ti_q, 14'b0, pending_hw_int, ip_sw_q, 1'b0, exc_code_q, 2'b0};

    always_comb begin
        mfc0_rdata = 32'b0;
        case (mfc0_addr)
            ADDR_BADVADDR: mfc0_rdata = badvaddr_q;
            ADDR_COUNT:    mfc0_rdata = count_q;
            ADDR_COMPARE:  mfc0_rdata = compare_q;
            ADDR_STATUS:   mfc0_rdata = status_word;
            ADDR_CAUSE:    mfc0_rdata = cause_word;
            ADDR_EPC:      mfc0_rdata = epc_q;
            default:       mfc0_rdata = 32'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_q <= 32'b0;
            count_q    <= 32'b0;
            compare_q  <= 32'b0;
            epc_q      <= 32'b0;
            im_q       <= 8'b0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= 2'b0;
            exc_code_q <= 5'b0;
            div_q      <= 4'b0;
            hw_sync1_q <= 6'b0;
            hw_sync2_q <= 6'b0;
        end else begin
            hw_sync1_q <= hardware_int;
            hw_sync2_q <= hw_sync1_q;

            if (wr_count) begin
                count_q <= mtc0_wdata;
                div_q   <= 4'b0;
            end else if (div_q == DIV_LAST) begin
                count_q <= count_q + 32'd1;
                div_q   <= 4'b0;
            end else begin
                div_q <= div_q + 4'd1;
            end

            if (wr_compare) begin
                compare_q <= mtc0_wdata;
            end
            // A Compare write wins over a match seen in the same cycle.
            if (wr_compare) begin
                ti_q <= 1'b0;
            end else if ((compare_q != 32'b0) && (count_q == compare_q)) begin
                ti_q <= 1'b1;
            end

            if (wr_status) begin
                im_q <= mtc0_wdata[15:8];
                ie_q <= mtc0_wdata[0];
            end
            if (is_exception) begin
                exl_q <= 1'b1;
            end else if (eret) begin
                exl_q <= 1'b0;
            end else if (wr_status) begin
                exl_q <= mtc0_wdata[1];
            end

            if (wr_cause) begin
                ip_sw_q <= mtc0_wdata[9:8];
            end
            if (is_exception) begin
                exc_code_q <= excep_code;
            end
            // Nested exceptions keep the original return point and BD flag.
            if (is_exception && !exl_q) begin
                bd_q  <= is_bd;
                epc_q <= excep_pc;
            end else if (wr_epc) begin
                epc_q <= mtc0_wdata;
            end

            // BadVAddr is read-only to software; only a faulting access loads it.
            if (is_exception && we_badvaddr) begin
                badvaddr_q <= badvaddr;
            end
        end
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: reset checks, a vector table, directed corner sequences, then randomized traffic against a reference model.
module tb_cp0_regs;
    localparam int DIV = 2;
    localparam logic [31:0] BEV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mtc0_we = 1'b0;
    logic [4:0]  mtc0_addr = 5'd0;
    logic [31:0] mtc0_wdata = 32'd0;
    logic [4:0]  mfc0_addr = 5'd0;
    logic [31:0] mfc0_rdata;
    logic        is_exception = 1'b0;
    logic [4:0]  excep_code = 5'd0;
    logic        is_bd = 1'b0;
    logic [31:0] excep_pc = 32'd0;
    logic        we_badvaddr = 1'b0;
    logic [31:0] badvaddr = 32'd0;
    logic        eret = 1'b0;
    logic [5:0]  hardware_int = 6'd0;
    logic        is_ie, is_exl;
    logic [7:0]  int_mask;
    logic [1:0]  soft_int;
    logic [31:0] epc;
    logic [5:0]  pending_hw_int;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cp0_regs #(.COUNT_DIV(DIV)) dut (
        .clk(clk), .resetn(resetn),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
        .is_exception(is_exception), .excep_code(excep_code), .is_bd(is_bd),
        .excep_pc(excep_pc), .we_badvaddr(we_badvaddr), .badvaddr(badvaddr),
        .eret(eret), .hardware_int(hardware_int),
        .is_ie(is_ie), .is_exl(is_exl), .int_mask(int_mask), .soft_int(soft_int),
        .epc(epc), .pending_hw_int(pending_hw_int)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        mfc0_addr = a;
        #1;
        d = mfc0_rdata;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        mtc0_we = 0; is_exception = 0; eret = 0; we_badvaddr = 0;
        excep_code = 0; is_bd = 0; excep_pc = 0; badvaddr = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1; mtc0_addr = a; mtc0_wdata = d;
        step();
        mtc0_we = 0;
    endtask

    function automatic logic [17:0] outs_now();
        return {is_ie, is_exl, int_mask, soft_int, pending_hw_int};
    endfunction

    // Reference model: architectural registers kept as words, Count derived from elapsed cycles.
    logic [31:0] m_st, m_epc, m_bva, m_cmp, m_base;
    logic        m_bd, m_ti;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    int unsigned m_cyc;
    logic [5:0]  hist[$];

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_cyc / DIV);
    endfunction

    function automatic logic [5:0] m_pend();
        logic [5:0] h;
        h = hist[1];
        return {h[5] | m_ti, h[4:0]};
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
            5'd9:  return m_count();
            5'd11: return m_cmp;
            5'd12: return m_st;
            5'd13: return {m_bd, m_ti, 14'b0, m_pend(), m_ipsw, 1'b0, m_code, 2'b0};
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_st = BEV; m_epc = 0; m_bva = 0; m_cmp = 0; m_base = 0;
        m_bd = 0; m_ti = 0; m_ipsw = 0; m_code = 0; m_cyc = 0;
        hist = {6'd0, 6'd0};
    endtask

    task automatic model_step();
        logic [31:0] oc;
        logic oexl, match;
        oc = m_count();
        oexl = m_st[1];
        match = (m_cmp != 0) && (oc == m_cmp);
        m_cyc++;
        if (mtc0_we) begin
            case (mtc0_addr)
                5'd9:  begin m_base = mtc0_wdata; m_cyc = 0; end
                5'd11: m_cmp = mtc0_wdata;
                5'd12: m_st = (mtc0_wdata & 32'h0000_FF03) | BEV;
                5'd13: m_ipsw = mtc0_wdata[9:8];
                5'd14: m_epc = mtc0_wdata;
                default: ;
            endcase
        end
        m_ti = (m_ti | match) & !(mtc0_we && mtc0_addr == 5'd11);
        if (eret && !is_exception) m_st[1] = 1'b0;
        if (is_exception) begin
            m_st[1] = 1'b1;
            m_code = excep_code;
            if (!oexl) begin m_epc = excep_pc; m_bd = is_bd; end
            if (we_badvaddr) m_bva = badvaddr;
        end
        hist.push_front(hardware_int);
        if (hist.size() > 3) void'(hist.pop_back());
    endtask

    vec_t vecs[12];
    logic [31:0] d;
    int n;

    initial begin
        vecs[0]  = '{1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
        vecs[1]  = '{1, 5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000};
        vecs[2]  = '{1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
        vecs[3]  = '{1, 5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
        vecs[4]  = '{1, 5'd11, 32'h1234_5678, 5'd11, 32'h1234_5678};
        vecs[5]  = '{1, 5'd10, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000};
        vecs[6]  = '{1, 5'd8,  32'hFFFF_FFFF, 5'd8,  32'h0000_0000};
        vecs[7]  = '{1, 5'd0,  32'h0000_0001, 5'd0,  32'h0000_0000};
        vecs[8]  = '{1, 5'd31, 32'hFFFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[9]  = '{1, 5'd9,  32'h0000_0100, 5'd9,  32'h0000_0100};
        vecs[10] = '{1, 5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
        vecs[11] = '{0, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_0000};

        // Reset state while reset is held
        #12;
        chk("rst_outs", 32'(outs_now()), 32'd0);
        chk("rst_epc", epc, 32'd0);
        rd(5'd12, d); chk("rst_status", d, BEV);
        rd(5'd9, d);  chk("rst_count", d, 32'd0);
        @(negedge clk);
        resetn = 1;

        for (int i = 0; i < 12; i++) begin
            mtc0_we = vecs[i].we; mtc0_addr = vecs[i].waddr; mtc0_wdata = vecs[i].wdata;
            step();
            mtc0_we = 0;
            rd(vecs[i].raddr, d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // Same-cycle MFC0 sees the value before the MTC0 lands
        mtc0_we = 1; mtc0_addr = 5'd14; mtc0_wdata = 32'h1111_1111;
        rd(5'd14, d); chk("no_bypass_old", d, 32'hDEAD_BEEF);
        step(); mtc0_we = 0;
        rd(5'd14, d); chk("no_bypass_new", d, 32'h1111_1111);

        // Exception entry
        mtc0(5'd12, 32'h0000_FF01);
        is_exception = 1; excep_code = 5'h04; is_bd = 1; excep_pc = 32'hBFC0_0100;
        we_badvaddr = 1; badvaddr = 32'h1234_5679;
        step(); clear_inputs();
        chk("exc_epc", epc, 32'hBFC0_0100);
        rd(5'd13, d); chk("exc_cause", d, 32'h8000_0010);
        rd(5'd8, d);  chk("exc_badvaddr", d, 32'h1234_5679);
        chk("exc_exl", 32'(is_exl), 32'd1);

        // Nested exception keeps EPC and BD
        is_exception = 1; excep_code = 5'h0C; is_bd = 0; excep_pc = 32'h8000_0000;
        step(); clear_inputs();
        chk("nest_epc", epc, 32'hBFC0_0100);
        rd(5'd13, d); chk("nest_cause", d, 32'h8000_0030);

        // ERET alone, then the three-way collision
        eret = 1; step(); clear_inputs();
        chk("eret_exl", 32'(is_exl), 32'd0);
        eret = 1; is_exception = 1; mtc0_we = 1; mtc0_addr = 5'd12; mtc0_wdata = 32'd0;
        step(); clear_inputs();
        chk("coll_exl", 32'(is_exl), 32'd1);
        chk("coll_im", 32'(int_mask), 32'd0);

        // Timer interrupt
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        n = 0;
        while (n < 40 && !pending_hw_int[5]) begin step(); n++; end
        n_cmp++;
        if (n < 10 || n > 11) begin
            n_fail++;
            $display("FAIL timer_latency: got %0d cycles expected 10..11", n);
        end
        rd(5'd13, d); chk("timer_ti", 32'(d[30]), 32'd1);
        mtc0(5'd11, 32'd5);
        chk("timer_clr_pend", 32'(pending_hw_int[5]), 32'd0);
        rd(5'd13, d); chk("timer_clr_ti", 32'(d[30]), 32'd0);

        // Synchronizer latency
        hardware_int = 6'b000100;
        step(); hardware_int = 6'd0;
        rd(5'd13, d); chk("sync_1cyc", 32'(d[12]), 32'd0);
        step();
        rd(5'd13, d); chk("sync_2cyc", 32'(d[12]), 32'd1);
        step();
        rd(5'd13, d); chk("sync_3cyc", 32'(d[12]), 32'd0);

        // Reset dropped mid-cycle during an exception
        is_exception = 1; excep_code = 5'h07; excep_pc = 32'hCAFE_0000; we_badvaddr = 1; badvaddr = 32'hFFFF_0000;
        #2 resetn = 0;
        #1;
        chk("arst_outs", 32'(outs_now()), 32'd0);
        chk("arst_epc", epc, 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        for (int a = 8; a < 15; a++) begin
            rd(5'(a), d);
            chk($sformatf("arst_reg%0d", a), d, (a == 12) ? BEV : 32'd0);
        end
        @(negedge clk);
        resetn = 1;
        model_reset();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ra;
            mtc0_we = ($urandom % 2) == 0;
            case ($urandom % 8)
                0: mtc0_addr = 5'd8;
                1: mtc0_addr = 5'd9;
                2: mtc0_addr = 5'd11;
                3: mtc0_addr = 5'd12;
                4: mtc0_addr = 5'd13;
                5: mtc0_addr = 5'd14;
                default: mtc0_addr = 5'($urandom);
            endcase
            mtc0_wdata = $urandom;
            if (mtc0_addr == 5'd11 && ($urandom % 2) == 0) mtc0_wdata = m_count() + 32'($urandom_range(0, 3));
            if (mtc0_addr == 5'd9 && ($urandom % 4) == 0) mtc0_wdata = 32'hFFFF_FFFE;
            is_exception = ($urandom % 8) == 0;
            eret = ($urandom % 6) == 0;
            excep_code = 5'($urandom); is_bd = 1'($urandom); excep_pc = $urandom;
            we_badvaddr = 1'($urandom); badvaddr = $urandom;
            hardware_int = 6'($urandom);
            @(posedge clk);
            model_step();
            @(negedge clk);
            ra = (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom_range(8, 14));
            rd(ra, d);
            chk($sformatf("rnd%0d_reg%0d", i, ra), d, m_rd(ra));
            chk($sformatf("rnd%0d_outs", i), 32'(outs_now()),
                32'({m_st[0], m_st[1], m_st[15:8], m_ipsw, m_pend()}));
            chk($sformatf("rnd%0d_epc", i), epc, m_epc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
